collision_pair_scanner: RTL and testbench

COLLISION_PAIR_SCANNER -- requirements
Module: collision_pair_scanner

---
 rtl/billiard_pkg.sv | 33 +++
 rtl/ball_collision_detect.sv | 36 +++
 rtl/collision_pair_scanner.sv | 138 +++++++++++++
 tb/tb_collision_pair_scanner.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// Shared types and width helpers for the billiard collision scanner.
package billiard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_EMIT,
        ST_DONE
    } scan_state_t;

    function automatic int clog2_int(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

    function automatic int idx_width(input int num_balls);
        return clog2_int(num_balls);
    endfunction

    // Must hold the full count of unordered pairs, including the all-colliding case.
    function automatic int cnt_width(input int num_balls);
        return clog2_int(num_balls * (num_balls - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/ball_collision_detect.sv
// Combinational test: squared centre distance strictly below squared diameter.
module ball_collision_detect #(
    parameter int N = 32
) (
    input  logic signed [N-1:0] i_x_a,
    input  logic signed [N-1:0] i_y_a,
    input  logic signed [N-1:0] i_x_b,
    input  logic signed [N-1:0] i_y_b,
    input  logic signed [N-1:0] i_radius,
    output logic                o_collide
);

    logic signed [N-1:0]   w_dx;
    logic signed [N-1:0]   w_dy;
    logic signed [N-1:0]   w_diam;
    logic signed [2*N-1:0] w_dx_ext;
    logic signed [2*N-1:0] w_dy_ext;
    logic signed [2*N-1:0] w_diam_ext;
    logic signed [2*N-1:0] w_dist_sq;
    logic signed [2*N-1:0] w_diam_sq;

    assign w_dx   = i_x_a - i_x_b;
    assign w_dy   = i_y_a - i_y_b;
    assign w_diam = i_radius <<< 1;

    // Differences wrap at N bits; only the squares are carried at 2N.
    assign w_dx_ext   = {{N{w_dx[N-1]}}, w_dx};
    assign w_dy_ext   = {{N{w_dy[N-1]}}, w_dy};
    assign w_diam_ext = {{N{w_diam[N-1]}}, w_diam};

    assign w_dist_sq = (w_dx_ext * w_dx_ext) + (w_dy_ext * w_dy_ext);
    assign w_diam_sq = w_diam_ext * w_diam_ext;

    assign o_collide = (w_dist_sq < w_diam_sq);

endmodule

// File: rtl/collision_pair_scanner.sv
// Walks all ball pairs (i < j), reads both positions, and emits colliding pairs
// through a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for start
//   READ  | position read strobe for pair (i, j)
//   EVAL  | read data present, collision decided
//   EMIT  | colliding pair held until pair_ready
//   DONE  | one-cycle done pulse
module collision_pair_scanner
    import billiard_pkg::*;
#(
    parameter  int N         = 32,
    parameter  int NUM_BALLS = 16,
    localparam int IDX_W     = idx_width(NUM_BALLS),
    localparam int CNT_W     = cnt_width(NUM_BALLS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N-1:0] radius,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [IDX_W-1:0]    rd_addr_a,
    output logic [IDX_W-1:0]    rd_addr_b,
    input  logic signed [N-1:0] rd_x_a,
    input  logic signed [N-1:0] rd_y_a,
    input  logic signed [N-1:0] rd_x_b,
    input  logic signed [N-1:0] rd_y_b,
    output logic                pair_valid,
    input  logic                pair_ready,
    output logic [IDX_W-1:0]    pair_i,
    output logic [IDX_W-1:0]    pair_j,
    output logic [CNT_W-1:0]    pair_count
);

    localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);
    localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);

    scan_state_t         r_state;
    scan_state_t         w_state_nxt;
    scan_state_t         w_adv_state;
    logic [IDX_W-1:0]    r_i;
    logic [IDX_W-1:0]    r_j;
    logic [IDX_W-1:0]    r_pair_i;
    logic [IDX_W-1:0]    r_pair_j;
    logic [CNT_W-1:0]    r_pair_count;
    logic signed [N-1:0] r_radius;
    logic                w_collide;
    logic                w_more_j;
    logic                w_more_i;
    logic                w_accept;
    logic                w_handshake;
    logic                w_advance;

    ball_collision_detect #(
        .N (N)
    ) u_detect (
        .i_x_a     (rd_x_a),
        .i_y_a     (rd_y_a),
        .i_x_b     (rd_x_b),
        .i_y_b     (rd_y_b),
        .i_radius  (r_radius),
        .o_collide (w_collide)
    );

    assign w_more_j    = (r_j < LAST_J);
    assign w_more_i    = (r_i < LAST_I);
    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_handshake = (r_state == ST_EMIT) && pair_ready;
    assign w_advance   = ((r_state == ST_EVAL) && !w_collide) || w_handshake;
    assign w_adv_state = (w_more_j || w_more_i) ? ST_READ : ST_DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_READ;
            ST_READ: w_state_nxt = ST_EVAL;
            ST_EVAL: w_state_nxt = w_collide ? ST_EMIT : w_adv_state;
            ST_EMIT: if (pair_ready) w_state_nxt = w_adv_state;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i          <= '0;
            r_j          <= '0;
            r_pair_i     <= '0;
            r_pair_j     <= '0;
            r_pair_count <= '0;
            r_radius     <= '0;
        end else begin
            if (w_accept) begin
                r_radius     <= radius;
                r_i          <= '0;
                r_j          <= IDX_W'(1);
                r_pair_count <= '0;
            end
            // Row wrap starts j just past the new i, so i < j always holds.
            if (w_advance) begin
                if (w_more_j) begin
                    r_j <= r_j + IDX_W'(1);
                end else if (w_more_i) begin
                    r_i <= r_i + IDX_W'(1);
                    r_j <= r_i + IDX_W'(2);
                end
            end
            if ((r_state == ST_EVAL) && w_collide) begin
                r_pair_i <= r_i;
                r_pair_j <= r_j;
            end
            if (w_handshake) begin
                r_pair_count <= r_pair_count + CNT_W'(1);
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign rd_en      = (r_state == ST_READ);
    assign pair_valid = (r_state == ST_EMIT);
    assign rd_addr_a  = r_i;
    assign rd_addr_b  = r_j;
    assign pair_i     = r_pair_i;
    assign pair_j     = r_pair_j;
    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_collision_pair_scanner.sv
// Directed plus randomized checks of the pair scanner against a nested-loop model.
module tb_collision_pair_scanner;

    localparam int N  = 32;
    localparam int NB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                start;
    logic signed [N-1:0] radius;
    logic                busy, done, rd_en, pair_valid, pair_ready;
    logic [3:0]          rd_addr_a, rd_addr_b, pair_i, pair_j;
    logic [6:0]          pair_count;
    logic signed [N-1:0] rd_x_a, rd_y_a, rd_x_b, rd_y_b;

    logic                start2, ready2;
    logic signed [N-1:0] radius2;
    logic                busy2, done2, rd_en2, pair_valid2;
    logic [0:0]          rd_addr_a2, rd_addr_b2, pair_i2, pair_j2;
    logic [0:0]          pair_count2;
    logic signed [N-1:0] rd_x_a2, rd_y_a2, rd_x_b2, rd_y_b2;

    int bx[NB];
    int by[NB];
    int tests = 0;
    int fails = 0;
    int ready_mode = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    int got_q[$];
    int exp_q[$];
    int got2_q[$];

    collision_pair_scanner #(.N(N), .NUM_BALLS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .radius(radius),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_x_a(rd_x_a), .rd_y_a(rd_y_a), .rd_x_b(rd_x_b), .rd_y_b(rd_y_b),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_i(pair_i), .pair_j(pair_j), .pair_count(pair_count)
    );

    collision_pair_scanner #(.N(N), .NUM_BALLS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .radius(radius2),
        .busy(busy2), .done(done2), .rd_en(rd_en2),
        .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2),
        .rd_x_a(rd_x_a2), .rd_y_a(rd_y_a2), .rd_x_b(rd_x_b2), .rd_y_b(rd_y_b2),
        .pair_valid(pair_valid2), .pair_ready(ready2),
        .pair_i(pair_i2), .pair_j(pair_j2), .pair_count(pair_count2)
    );

    // Position memory: one-cycle read latency behind rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_x_a <= bx[rd_addr_a];
            rd_y_a <= by[rd_addr_a];
            rd_x_b <= bx[rd_addr_b];
            rd_y_b <= by[rd_addr_b];
        end
        if (rd_en2) begin
            rd_x_a2 <= bx[rd_addr_a2];
            rd_y_a2 <= by[rd_addr_a2];
            rd_x_b2 <= bx[rd_addr_b2];
            rd_y_b2 <= by[rd_addr_b2];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Consumer: 0 = always ready, 1 = random, 2 = stall 10 cycles per pair.
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: pair_ready = 1'b1;
            1: pair_ready = 1'($urandom_range(0, 1));
            default: begin
                if (pair_valid) begin
                    if (stall_cnt < 10) begin
                        pair_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        pair_ready = 1'b1;
                    end
                end else begin
                    pair_ready = 1'b0;
                    stall_cnt  = 0;
                end
            end
        endcase
    end

    logic       prev_stall = 1'b0;
    logic [3:0] prev_i = '0;
    logic [3:0] prev_j = '0;

    always @(negedge clk) begin
        if (prev_stall && rst_n) begin
            chk("stall_valid", 64'(pair_valid), 64'd1);
            chk("stall_pair_i", 64'(pair_i), 64'(prev_i));
            chk("stall_pair_j", 64'(pair_j), 64'(prev_j));
        end
        prev_stall = pair_valid && !pair_ready;
        prev_i     = pair_i;
        prev_j     = pair_j;
        if (pair_valid && pair_ready) got_q.push_back(int'(pair_i) * 256 + int'(pair_j));
        if (done) done_cnt++;
        if (pair_valid2 && ready2) got2_q.push_back(int'(pair_i2) * 256 + int'(pair_j2));
    end

    // Reference: every i<j pair in order, colliding when squared distance < (2r)^2.
    task automatic build_exp(input int r);
        longint dx, dy, d2;
        exp_q.delete();
        d2 = 4 * longint'(r) * longint'(r);
        for (int i = 0; i < NB; i++) begin
            for (int j = i + 1; j < NB; j++) begin
                dx = longint'(bx[i]) - longint'(bx[j]);
                dy = longint'(by[i]) - longint'(by[j]);
                if (dx * dx + dy * dy < d2) exp_q.push_back(i * 256 + j);
            end
        end
    endtask

    task automatic run_scan(input int r, input string tag);
        int cyc;
        int seen;
        int n;
        int exp_cyc;
        build_exp(r);
        got_q.delete();
        @(posedge clk);
        #1;
        start  = 1'b1;
        radius = r;
        cyc    = 0;
        seen   = 0;
        while (seen == 0 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start  = 1'b0;
                radius = $urandom;
                chk({tag, "_busy"}, 64'(busy), 64'd1);
                chk({tag, "_rd_en"}, 64'(rd_en), 64'd1);
                chk({tag, "_addr_a0"}, 64'(rd_addr_a), 64'd0);
                chk({tag, "_addr_b0"}, 64'(rd_addr_b), 64'd1);
            end else if (cyc == 3) begin
                start = 1'b1;
            end else if (cyc == 4) begin
                start = 1'b0;
            end
            if (done) seen = 1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        n = exp_q.size();
        exp_cyc = 2 * (NB * (NB - 1) / 2) + n + 1;
        if (ready_mode == 0) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        if (ready_mode == 2) chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc + 10 * n));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_npairs"}, 64'(got_q.size()), 64'(n));
        for (int k = 0; k < n && k < got_q.size(); k++) chk({tag, "_pair"}, 64'(got_q[k]), 64'(exp_q[k]));
        chk({tag, "_count"}, 64'(pair_count), 64'(n));
    endtask

    task automatic far_field();
        for (int k = 0; k < NB; k++) begin
            bx[k] = 1000 + k * 1000;
            by[k] = 5000;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int found;
        int dsnap;
        start = 1'b0; radius = '0; pair_ready = 1'b0;
        start2 = 1'b0; radius2 = '0; ready2 = 1'b1;
        for (int k = 0; k < NB; k++) begin bx[k] = 0; by[k] = 0; end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_valid", 64'(pair_valid), 64'd0);
        chk("rst_count", 64'(pair_count), 64'd0);
        chk("rst_addr_b", 64'(rd_addr_b), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(busy), 64'd0);

        // Widely spaced balls: no pairs, pure 2-cycle-per-pair walk.
        for (int k = 0; k < NB; k++) begin bx[k] = k * 100; by[k] = 0; end
        ready_mode = 0;
        run_scan(10, "spread");

        far_field();
        bx[0] = 0; by[0] = 0; bx[1] = 10; by[1] = 0;
        run_scan(6, "overlap");
        chk("overlap_count1", 64'(pair_count), 64'd1);
        bx[1] = 12;
        run_scan(6, "touch");
        chk("touch_count0", 64'(pair_count), 64'd0);

        far_field();
        for (int k = 3; k <= 5; k++) begin bx[k] = 50; by[k] = 50; end
        ready_mode = 2;
        run_scan(5, "stall");

        // Reset while the second pair is held in EMIT.
        got_q.delete();
        @(posedge clk);
        #1;
        start = 1'b1; radius = 5;
        found = 0; cyc = 0;
        while (found == 0 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (pair_valid && pair_count == 7'd1) found = 1;
        end
        chk("midrst_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(pair_valid), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_count", 64'(pair_count), 64'd0);
        chk("midrst_pair_i", 64'(pair_i), 64'd0);
        chk("midrst_pair_j", 64'(pair_j), 64'd0);
        chk("midrst_addr_a", 64'(rd_addr_a), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        dsnap = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("postrst_no_pair", 64'(got_q.size()), 64'd0);
        chk("postrst_no_done", 64'(done_cnt), 64'(dsnap));
        chk("postrst_idle", 64'(busy), 64'd0);
        ready_mode = 0;
        run_scan(5, "rescan");

        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < NB; k++) begin
                bx[k] = int'($urandom_range(0, 300));
                by[k] = int'($urandom_range(0, 300));
            end
            ready_mode = (t == 0) ? 0 : 1;
            run_scan(int'($urandom_range(5, 40)), "rand");
        end
        ready_mode = 0;

        // Two-ball instance: single colliding pair, restart pulse ignored.
        bx[0] = 0; by[0] = 0; bx[1] = 3; by[1] = 4;
        got2_q.delete();
        @(posedge clk);
        #1;
        start2 = 1'b1; radius2 = 3;
        found = 0; cyc = 0;
        while (found == 0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) begin
                start2 = 1'b0;
                chk("nb2_rd_en", 64'(rd_en2), 64'd1);
                chk("nb2_addr_b", 64'(rd_addr_b2), 64'd1);
            end else if (cyc == 2) begin
                start2 = 1'b1;
            end else begin
                start2 = 1'b0;
            end
            if (done2) found = 1;
        end
        chk("nb2_done_seen", 64'(found), 64'd1);
        chk("nb2_cycles", 64'(cyc), 64'd4);
        chk("nb2_npairs", 64'(got2_q.size()), 64'd1);
        if (got2_q.size() > 0) chk("nb2_pair", 64'(got2_q[0]), 64'd1);
        chk("nb2_count", 64'(pair_count2), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("nb2_no_restart", 64'(busy2), 64'd0);
        chk("nb2_no_extra", 64'(got2_q.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
